asp_host_wr_irq_arb: RTL

Parametrised write-channel arbiter between the ASP write-DMA source and the host-memory (PIM) write sink, carrying NUM_IRQ interrupt lines, write fences and fence magic-number writes. It sits between the board DMA write path and the PIM host-channel Avalon write port. Interrupts and fences are inserted only at burst boundaries. Pending interrupts are granted round-robin instead of by fixed priority.

---
 rtl/asp_host_wr_irq_arb.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/asp_host_wr_irq_arb.sv
// asp_host_wr_irq_arb
// Write-channel arbiter between the ASP write-DMA source and the host (PIM)
// write sink. It inserts single-beat interrupt writes (round-robin across
// NUM_IRQ lines) and fence + magic-number writes, only at burst boundaries.
// Optional feature macro: ASP_WR_IRQ_COALESCE_CNT_EN adds per-line 8-bit
// saturating counters of interrupt edges that arrived while already pending.
module asp_host_wr_irq_arb #(
  parameter int NUM_IRQ          = 4,
  parameter int ADDR_W           = 48,
  parameter int DATA_W           = 512,
  parameter int BURST_W          = 7,
  parameter int USER_W           = 8,
  parameter int UFLAG_IRQ        = 0,
  parameter int UFLAG_FENCE      = 1,
  parameter int RESET_PIPE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_IRQ-1:0]     asp_irq,
  input  logic                   wr_fence_flag,
  input  logic                   src_wr_write,
  input  logic [ADDR_W-1:0]      src_wr_address,
  input  logic [DATA_W-1:0]      src_wr_writedata,
  input  logic [DATA_W/8-1:0]    src_wr_byteenable,
  input  logic [BURST_W-1:0]     src_wr_burstcount,
  output logic                   src_wr_waitrequest,
  output logic                   snk_wr_write,
  output logic [ADDR_W-1:0]      snk_wr_address,
  output logic [DATA_W-1:0]      snk_wr_writedata,
  output logic [DATA_W/8-1:0]    snk_wr_byteenable,
  output logic [BURST_W-1:0]     snk_wr_burstcount,
  output logic [USER_W-1:0]      snk_wr_user,
  input  logic                   snk_wr_waitrequest,
  output logic [NUM_IRQ*8-1:0]   irq_coalesce_cnt
);

  localparam int IRQ_ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [IRQ_ID_W:0] NUM_IRQ_X = (IRQ_ID_W + 1)'(NUM_IRQ);
  localparam logic [IRQ_ID_W-1:0] RR_RESET = IRQ_ID_W'(NUM_IRQ - 1);

  typedef enum logic {S_IDLE, S_MAGIC} state_e;

  // Internal reset: asserts one cycle after reset, releases RESET_PIPE_DEPTH
  // cycles after reset drops.
  logic [RESET_PIPE_DEPTH-1:0] rst_pipe_q;
  logic                        rst_l;

  logic [NUM_IRQ-1:0]  asp_irq_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  irq_set;
  logic [NUM_IRQ-1:0]  grant_mask;
  logic [BURST_W-1:0]  beats_left_q, beats_left_d;
  logic [IRQ_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IRQ_ID_W-1:0] grant_id;
  logic                grant_found;
  logic                irq_grant;
  state_e              state_q, state_d;
  logic                boundary;
  logic                src_accept;

  // Reset pipeline shift register.
  always_ff @(posedge clk) begin
    if (reset) rst_pipe_q <= '1;
    else       rst_pipe_q <= rst_pipe_q << 1;
  end

  assign rst_l      = rst_pipe_q[RESET_PIPE_DEPTH-1];
  assign irq_set    = asp_irq & ~asp_irq_q;
  assign boundary   = (beats_left_q == '0);
  assign src_accept = src_wr_write & ~src_wr_waitrequest & ~rst_l;

  // Round-robin search: first pending line at or after rr_ptr+1, wrapping.
  always_comb begin
    logic [IRQ_ID_W:0] cand;
    cand        = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IRQ_ID_W + 1)'(k + 1);
      if (cand >= NUM_IRQ_X) cand = cand - NUM_IRQ_X;
      if (!grant_found && pending_q[cand[IRQ_ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[IRQ_ID_W-1:0];
      end
    end
  end

  // Slot decision and sink muxing; pass-through unless a boundary slot is
  // taken by an interrupt or a fence.
  always_comb begin
    snk_wr_write       = src_wr_write & ~rst_l;
    snk_wr_address     = src_wr_address;
    snk_wr_writedata   = src_wr_writedata;
    snk_wr_byteenable  = src_wr_byteenable;
    snk_wr_burstcount  = src_wr_burstcount;
    snk_wr_user        = '0;
    src_wr_waitrequest = snk_wr_waitrequest;
    state_d            = state_q;
    irq_grant          = 1'b0;
    if (!rst_l && boundary && !snk_wr_waitrequest) begin
      if (grant_found) begin
        // Interrupt beat preempts both fence and data (also in MAGIC).
        irq_grant              = 1'b1;
        snk_wr_write           = 1'b1;
        snk_wr_burstcount      = BURST_W'(1);
        snk_wr_address         = ADDR_W'(grant_id);
        snk_wr_writedata       = '0;
        snk_wr_byteenable      = '1;
        snk_wr_user[UFLAG_IRQ] = 1'b1;
        src_wr_waitrequest     = 1'b1;
      end else if (state_q == S_IDLE && src_wr_write && wr_fence_flag) begin
        // Fence beat reuses the source fields; the source beat is held
        // and goes out next as the magic number.
        snk_wr_user[UFLAG_FENCE] = 1'b1;
        src_wr_waitrequest       = 1'b1;
        state_d                  = S_MAGIC;
      end else if (state_q == S_MAGIC && src_wr_write) begin
        state_d = S_IDLE;
      end
    end
  end

  // Next-state for pending set, round-robin pointer and burst tracking.
  always_comb begin
    grant_mask   = irq_grant ? (NUM_IRQ'(1) << grant_id) : '0;
    pending_d    = (pending_q & ~grant_mask) | irq_set;
    rr_ptr_d     = irq_grant ? grant_id : rr_ptr_q;
    beats_left_d = beats_left_q;
    if (src_accept) begin
      beats_left_d = boundary ? (src_wr_burstcount - BURST_W'(1))
                              : (beats_left_q - BURST_W'(1));
    end
  end

  // State registers, all cleared while the internal reset is high.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      asp_irq_q    <= '0;
      pending_q    <= '0;
      beats_left_q <= '0;
      rr_ptr_q     <= RR_RESET;
      state_q      <= S_IDLE;
    end else begin
      asp_irq_q    <= asp_irq;
      pending_q    <= pending_d;
      beats_left_q <= beats_left_d;
      rr_ptr_q     <= rr_ptr_d;
      state_q      <= state_d;
    end
  end

`ifdef ASP_WR_IRQ_COALESCE_CNT_EN
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_coalesce
    logic [7:0] cnt_q, cnt_d;

    assign cnt_d = (irq_set[gi] && pending_q[gi] && cnt_q != 8'hFF)
                   ? cnt_q + 8'd1 : cnt_q;

    // Count edges that merged into an already-pending request.
    always_ff @(posedge clk) begin
      if (rst_l) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign irq_coalesce_cnt[8*gi +: 8] = cnt_q;
  end
`else
  assign irq_coalesce_cnt = '0;
`endif

endmodule
